// File: rtl/cpu_issue_if.sv
// Issue-controller bus: instruction stream in, VPU handshake, and decoded control out.
// master = CPU front end / testbench side, slave = cpu_issue_controller.
interface cpu_issue_if #(
  parameter int WAIT_W = 11,
  parameter int NCH    = 2,
  parameter int TO_W   = 16
);
  logic              instr_valid;
  logic [4:0]        opcode;
  logic              x_bit;
  logic [WAIT_W-1:0] wait_time;
  logic [TO_W-1:0]   timeout_lim;
  logic              resume;
  logic [NCH-1:0]    vpu_rdy;
  logic [NCH-1:0]    vpu_done;
  logic [NCH-1:0]    vpu_start;
  logic [19:0]       ctrl;
  logic              stall;
  logic              halt;
  logic              vpu_timeout;

  modport master (
    output instr_valid, opcode, x_bit, wait_time, timeout_lim, resume, vpu_rdy, vpu_done,
    input  vpu_start, ctrl, stall, halt, vpu_timeout
  );

  modport slave (
    input  instr_valid, opcode, x_bit, wait_time, timeout_lim, resume, vpu_rdy, vpu_done,
    output vpu_start, ctrl, stall, halt, vpu_timeout
  );
endinterface

// File: rtl/cpu_issue_controller.sv
// Instruction issue controller: decodes scalar opcodes into a control word,
// sequences NOP stalls, VPU channel issue/completion with timeout, and HALT.
module cpu_issue_controller #(
  parameter int WAIT_W    = 11,
  parameter int NCH       = 2,
  parameter int TO_W      = 16,
  parameter bit VPU_BLOCK = 1'b1
) (
  input logic       clk,
  input logic       rst,
  cpu_issue_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  // control word bit positions
  localparam int ALU = 0, PCR = 1, MEM2R = 2, WE0 = 3, WE1 = 4, RD0 = 5, RD1 = 6;
  localparam int MWE = 7, MRE = 8, ADDI = 9, JMPI = 10, LDU = 11, LDL = 12;
  localparam int BR = 13, JMP = 14, ZW = 15, NW = 16, VW = 17;

  typedef enum logic [2:0] {IDLE, WAIT, VPU_ISSUE, VPU_BUSY, HALTED} state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] timer_reg, timer_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [CH_W-1:0]   op_ch;
  logic [CH_W-1:0]   start_ch;
  logic              start_req, stall_c, halt_c, timeout_c;
  logic [19:0]       dec;
  logic              is_nop, is_halt, is_vpu;

  assign is_nop  = (bus.opcode == 5'b01111);
  assign is_halt = (bus.opcode == 5'b11111);
  assign is_vpu  = bus.opcode[4] && !is_halt;

  // channel select comes from the low opcode bits; a single channel is always 0
  if (NCH > 1) begin : g_multi_ch
    assign op_ch = bus.opcode[CH_W-1:0];
  end else begin : g_single_ch
    assign op_ch = '0;
  end

  // scalar opcode decode (VPU, NOP and HALT opcodes decode to nothing)
  always_comb begin
    dec = '0;
    case (bus.opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
        dec[RD0] = 1'b1; dec[RD1] = 1'b1; dec[ALU] = 1'b1; dec[WE0] = 1'b1;
        dec[ZW] = 1'b1; dec[NW] = 1'b1; dec[VW] = 1'b1;
      end
      5'b00100: begin
        dec[RD0] = 1'b1; dec[RD1] = ~bus.x_bit; dec[ALU] = 1'b1; dec[WE0] = 1'b1;
        dec[ADDI] = bus.x_bit; dec[ZW] = 1'b1; dec[NW] = 1'b1; dec[VW] = 1'b1;
      end
      5'b00101, 5'b00110, 5'b00111: begin
        dec[RD0] = 1'b1; dec[ALU] = 1'b1; dec[WE0] = 1'b1;
        dec[ZW] = 1'b1; dec[NW] = 1'b1; dec[VW] = 1'b1;
      end
      5'b01000: begin
        dec[RD0] = 1'b1; dec[RD1] = ~bus.x_bit; dec[WE0] = 1'b1; dec[WE1] = bus.x_bit;
      end
      5'b01001: begin
        dec[RD1] = 1'b1; dec[MRE] = 1'b1; dec[MEM2R] = 1'b1; dec[WE0] = 1'b1;
      end
      5'b01010: begin dec[RD0] = 1'b1; dec[WE0] = 1'b1; dec[LDU] = 1'b1; end
      5'b01011: begin dec[RD0] = 1'b1; dec[WE0] = 1'b1; dec[LDL] = 1'b1; end
      5'b01100: begin dec[RD1] = 1'b1; dec[MWE] = 1'b1; end
      5'b01101: begin
        dec[JMP] = 1'b1; dec[RD1] = ~bus.x_bit; dec[PCR] = 1'b1; dec[WE1] = 1'b1;
        dec[JMPI] = bus.x_bit;
      end
      5'b01110: dec[BR] = 1'b1;
      default: dec = '0;
    endcase
  end

  // next-state and per-cycle handshake outputs
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    to_cnt_next = to_cnt_reg;
    ch_next     = ch_reg;
    start_ch    = ch_reg;
    start_req   = 1'b0;
    stall_c     = 1'b0;
    halt_c      = 1'b0;
    timeout_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.instr_valid) begin
          if (is_nop) begin
            if (bus.wait_time != '0) begin
              timer_next = bus.wait_time;
              state_next = WAIT;
            end
          end else if (is_halt) begin
            state_next = HALTED;
          end else if (is_vpu) begin
            ch_next  = op_ch;
            start_ch = op_ch;
            if (bus.vpu_rdy[op_ch]) begin
              start_req   = 1'b1;
              to_cnt_next = '0;
              state_next  = VPU_BLOCK ? VPU_BUSY : IDLE;
            end else begin
              stall_c    = 1'b1;
              state_next = VPU_ISSUE;
            end
          end
        end
      end
      WAIT: begin
        stall_c    = 1'b1;
        timer_next = timer_reg - WAIT_W'(1);
        if (timer_reg == WAIT_W'(1)) state_next = IDLE;
      end
      VPU_ISSUE: begin
        if (bus.vpu_rdy[ch_reg]) begin
          start_req   = 1'b1;
          to_cnt_next = '0;
          state_next  = VPU_BLOCK ? VPU_BUSY : IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      VPU_BUSY: begin
        stall_c = 1'b1;
        // completion beats a coincident timeout
        if (bus.vpu_done[ch_reg]) begin
          state_next = IDLE;
        end else if (bus.timeout_lim != '0 && to_cnt_reg == bus.timeout_lim) begin
          timeout_c  = 1'b1;
          state_next = IDLE;
        end else if (to_cnt_reg != '1) begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      HALTED: begin
        stall_c = 1'b1;
        halt_c  = 1'b1;
        if (bus.resume) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // state and sequencing registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      to_cnt_reg <= '0;
      ch_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      to_cnt_reg <= to_cnt_next;
      ch_reg     <= ch_next;
    end
  end

  // one-hot start pulse; reset suppresses any pulse in its own cycle
  for (genvar gi = 0; gi < NCH; gi++) begin : g_start
    assign bus.vpu_start[gi] = start_req && (start_ch == CH_W'(gi)) && !rst;
  end

  assign bus.ctrl        = (state_reg == IDLE && bus.instr_valid) ? dec : '0;
  assign bus.stall       = stall_c && !rst;
  assign bus.halt        = halt_c && !rst;
  assign bus.vpu_timeout = timeout_c && !rst;
endmodule

// File: tb/tb_cpu_issue_controller.sv
// Self-checking bench for cpu_issue_controller: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_cpu_issue_controller;
  localparam int WAIT_W    = 11;
  localparam int NCH       = 2;
  localparam int TO_W      = 16;
  localparam bit VPU_BLOCK = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_issue_if #(.WAIT_W(WAIT_W), .NCH(NCH), .TO_W(TO_W)) bus ();

  cpu_issue_controller #(.WAIT_W(WAIT_W), .NCH(NCH), .TO_W(TO_W), .VPU_BLOCK(VPU_BLOCK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 nop wait, 2 waiting for ready, 3 vpu busy, 4 halted
  int m_mode = 0, m_wait = 0, m_ch = 0, m_busy = 0;
  int n_mode, n_wait, n_ch, n_busy;
  logic [19:0] e_ctrl;
  logic [1:0]  e_start;
  logic        e_stall, e_halt, e_to;

  logic [19:0] obs_ctrl;
  logic [1:0]  obs_start;
  logic        obs_stall, obs_halt, obs_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // control word expressed as which opcodes use each field
  function automatic logic [19:0] ref_ctrl(input int o, input bit x);
    logic [19:0] c;
    bit arith;
    c = '0;
    arith = (o <= 7);
    c[0]  = arith;
    c[1]  = (o == 13);
    c[2]  = (o == 9);
    c[3]  = (o <= 11);
    c[4]  = (o == 8 && x) || (o == 13);
    c[5]  = (o <= 8) || (o == 10) || (o == 11);
    c[6]  = (o <= 3) || ((o == 4 || o == 8 || o == 13) && !x) || (o == 9) || (o == 12);
    c[7]  = (o == 12);
    c[8]  = (o == 9);
    c[9]  = (o == 4) && x;
    c[10] = (o == 13) && x;
    c[11] = (o == 10);
    c[12] = (o == 11);
    c[13] = (o == 14);
    c[14] = (o == 13);
    c[15] = arith;
    c[16] = arith;
    c[17] = arith;
    return c;
  endfunction

  // channel became usable: fire the start and decide where we go afterwards
  task automatic model_issue(input int ch);
    e_start = 2'(1 << ch);
    n_busy  = 0;
    n_mode  = VPU_BLOCK ? 3 : 0;
  endtask

  // one clock cycle: drive, predict, compare at mid-cycle, then advance the model
  task automatic cyc(input bit r, input bit iv, input int op, input bit x, input int wt,
                     input int lim, input bit res, input logic [1:0] rdy, input logic [1:0] done);
    rst             = r;
    bus.instr_valid = iv;
    bus.opcode      = 5'(op);
    bus.x_bit       = x;
    bus.wait_time   = WAIT_W'(wt);
    bus.timeout_lim = TO_W'(lim);
    bus.resume      = res;
    bus.vpu_rdy     = rdy;
    bus.vpu_done    = done;
    #4;
    e_ctrl  = (m_mode == 0 && iv) ? ref_ctrl(op, x) : 20'h0;
    e_start = 2'b00; e_stall = 1'b0; e_halt = 1'b0; e_to = 1'b0;
    n_mode = m_mode; n_wait = m_wait; n_ch = m_ch; n_busy = m_busy;
    if (r) begin
      n_mode = 0; n_wait = 0; n_ch = 0; n_busy = 0;
    end else begin
      case (m_mode)
        0: if (iv) begin
          if (op == 15) begin
            if (wt != 0) begin n_mode = 1; n_wait = wt; end
          end else if (op == 31) begin
            n_mode = 4;
          end else if (op >= 16) begin
            n_ch = op % NCH;
            if (rdy[n_ch]) model_issue(n_ch);
            else begin e_stall = 1'b1; n_mode = 2; end
          end
        end
        1: begin
          e_stall = 1'b1;
          n_wait  = m_wait - 1;
          if (n_wait == 0) n_mode = 0;
        end
        2: if (rdy[m_ch]) model_issue(m_ch); else e_stall = 1'b1;
        3: begin
          e_stall = 1'b1;
          if (done[m_ch]) n_mode = 0;
          else if (lim != 0 && m_busy == lim) begin e_to = 1'b1; n_mode = 0; end
          else if (m_busy < (1 << TO_W) - 1) n_busy = m_busy + 1;
        end
        default: begin
          e_stall = 1'b1; e_halt = 1'b1;
          if (res) n_mode = 0;
        end
      endcase
    end
    obs_ctrl = bus.ctrl; obs_start = bus.vpu_start; obs_stall = bus.stall;
    obs_halt = bus.halt; obs_to = bus.vpu_timeout;
    chk("ctrl", 32'(obs_ctrl), 32'(e_ctrl));
    chk("vpu_start", 32'(obs_start), 32'(e_start));
    chk("stall", 32'(obs_stall), 32'(e_stall));
    chk("halt", 32'(obs_halt), 32'(e_halt));
    chk("vpu_timeout", 32'(obs_to), 32'(e_to));
    @(posedge clk);
    #1;
    m_mode = n_mode; m_wait = n_wait; m_ch = n_ch; m_busy = n_busy;
  endtask

  task automatic idle(input logic [1:0] rdy, input logic [1:0] done, input int lim);
    cyc(1'b0, 1'b0, 0, 1'b0, 0, lim, 1'b0, rdy, done);
  endtask

  int cnt_stall, cnt_start, cnt_to;

  initial begin
    // reset and quiet idle
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00);
    idle(2'b11, 2'b00, 0);
    idle(2'b00, 2'b11, 0);

    // NOP wait_time=3: exactly three stall cycles after the NOP cycle
    cyc(1'b0, 1'b1, 15, 1'b0, 3, 0, 1'b0, 2'b00, 2'b00);
    cnt_stall = 0;
    for (int i = 0; i < 5; i++) begin idle(2'b00, 2'b00, 0); cnt_stall += int'(obs_stall); end
    chk("nop3_stall_cycles", 32'(cnt_stall), 32'd3);

    // NOP wait_time=0: no stall at all
    cyc(1'b0, 1'b1, 15, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00);
    cnt_stall = int'(obs_stall);
    for (int i = 0; i < 2; i++) begin idle(2'b00, 2'b00, 0); cnt_stall += int'(obs_stall); end
    chk("nop0_stall_cycles", 32'(cnt_stall), 32'd0);

    // VPU op on ready channel 1, foreign done ignored, own done releases
    cyc(1'b0, 1'b1, 17, 1'b0, 0, 0, 1'b0, 2'b10, 2'b00);
    chk("vpu1_start_same_cycle", 32'(obs_start), 32'h2);
    chk("vpu1_no_stall_issue", 32'(obs_stall), 32'd0);
    cnt_stall = 0;
    idle(2'b11, 2'b01, 0); cnt_stall += int'(obs_stall);
    idle(2'b11, 2'b00, 0); cnt_stall += int'(obs_stall);
    idle(2'b11, 2'b10, 0); cnt_stall += int'(obs_stall);
    idle(2'b11, 2'b00, 0);
    chk("vpu1_busy_stall_cycles", 32'(cnt_stall), 32'd3);
    chk("vpu1_released", 32'(obs_stall), 32'd0);

    // VPU op on channel 0, not ready for four cycles
    cnt_stall = 0; cnt_start = 0;
    cyc(1'b0, 1'b1, 16, 1'b0, 0, 0, 1'b0, 2'b10, 2'b00);
    cnt_stall += int'(obs_stall);
    for (int i = 0; i < 3; i++) begin
      idle(2'b10, 2'b00, 0); cnt_stall += int'(obs_stall); cnt_start += int'(obs_start != 0);
    end
    idle(2'b01, 2'b00, 0);
    cnt_start += int'(obs_start == 2'b01);
    chk("vpu0_wait_stall_cycles", 32'(cnt_stall), 32'd4);
    chk("vpu0_single_start", 32'(cnt_start), 32'd1);
    idle(2'b01, 2'b01, 0);

    // timeout with limit 5 and no completion
    cyc(1'b0, 1'b1, 16, 1'b0, 0, 5, 1'b0, 2'b01, 2'b00);
    cnt_to = 0;
    for (int i = 0; i < 8; i++) begin idle(2'b01, 2'b00, 5); cnt_to += int'(obs_to); end
    chk("timeout_pulses", 32'(cnt_to), 32'd1);

    // completion coincident with the limit wins
    cyc(1'b0, 1'b1, 16, 1'b0, 0, 5, 1'b0, 2'b01, 2'b00);
    cnt_to = 0;
    for (int i = 0; i < 5; i++) begin idle(2'b01, 2'b00, 5); cnt_to += int'(obs_to); end
    idle(2'b01, 2'b01, 5); cnt_to += int'(obs_to);
    idle(2'b01, 2'b00, 5); cnt_to += int'(obs_to);
    chk("done_beats_timeout", 32'(cnt_to), 32'd0);

    // HALT, resume; then HALT with resume and reset together
    cyc(1'b0, 1'b1, 31, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 0);
    chk("halted_halt", 32'(obs_halt), 32'd1);
    idle(2'b00, 2'b00, 0);
    cyc(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 0);
    chk("resumed_halt", 32'(obs_halt), 32'd0);
    cyc(1'b0, 1'b1, 31, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 0);
    chk("rst_resume_halt", 32'(obs_halt), 32'd0);

    // ADD immediate decode
    cyc(1'b0, 1'b1, 4, 1'b1, 0, 0, 1'b0, 2'b00, 2'b00);
    chk("add_imm_ctrl", 32'(obs_ctrl), 32'h38229);

    // reset in the middle of a NOP wait
    cyc(1'b0, 1'b1, 15, 1'b0, 6, 0, 1'b0, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 0);
    idle(2'b00, 2'b00, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00);
    idle(2'b00, 2'b00, 0);
    chk("rst_mid_wait_stall", 32'(obs_stall), 32'd0);

    // reset in the middle of a VPU busy period: no timeout afterwards
    cyc(1'b0, 1'b1, 17, 1'b0, 0, 2, 1'b0, 2'b10, 2'b00);
    idle(2'b00, 2'b00, 2);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 2, 1'b0, 2'b00, 2'b00);
    cnt_to = 0;
    for (int i = 0; i < 4; i++) begin idle(2'b00, 2'b00, 2); cnt_to += int'(obs_to); end
    chk("rst_mid_busy_timeout", 32'(cnt_to), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, int'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
          $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
